ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 113 +++++++++++
 tb/tb_ram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester RAM access arbiter: IDLE -> ACCESS -> ACK for writes, IDLE -> ACCESS -> RWAIT -> ACK for reads.
// Optional macro RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; the default build is fixed priority (req0 wins).
module ram_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0_n,
    input  logic       rw1_n,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       ram_RWn,
    output logic [7:0] ram_raddr,
    output logic [7:0] ram_waddr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       any_req;
    logic       win;
    logic       sel;
    logic       sel_rw_n;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;

    always_comb any_req = req0 | req1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // last = 1 means requester 1 was granted most recently
    logic last;

    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (state == IDLE && any_req)
            last <= win;
    end

    always_comb win = (req0 && req1) ? ~last : req1;
`else
    always_comb win = ~req0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 1'b0;
            sel_rw_n  <= 1'b1;
            sel_addr  <= '0;
            sel_wdata <= '0;
            rdata     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                sel       <= win;
                sel_rw_n  <= win ? rw1_n  : rw0_n;
                sel_addr  <= win ? addr1  : addr0;
                sel_wdata <= win ? wdata1 : wdata0;
            end
            // RAM presents read data during RWAIT, one cycle after the address
            if (state == RWAIT)
                rdata <= ram_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        ack0      = 1'b0;
        ack1      = 1'b0;
        busy      = 1'b1;
        ram_RWn   = 1'b1;
        ram_raddr = '0;
        ram_waddr = '0;
        ram_wdata = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                ram_RWn   = sel_rw_n;
                ram_raddr = sel_addr;
                ram_waddr = sel_addr;
                ram_wdata = sel_wdata;
                state_nxt = sel_rw_n ? RWAIT : ACK;
            end
            RWAIT: state_nxt = ACK;
            ACK: begin
                ack0      = ~sel;
                ack1      = sel;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level reference model (grant order, latency, RAM contents).
// Expectations follow RAM_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_ram_arbiter;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, rw0_n, rw1_n;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, busy, ram_RWn;
    logic [7:0] rdata, ram_raddr, ram_waddr, ram_wdata, ram_rdata;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    bit         m_last;
    logic [7:0] m_rdata;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0_n(rw0_n), .rw1_n(rw1_n),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .ram_RWn(ram_RWn), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: write on RWn = 0, read data one cycle after the address
    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        forever begin
            @(posedge clk);
            if (!ram_RWn) mem[ram_waddr] <= ram_wdata;
            ram_rdata <= mem[ram_raddr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Arbitration rule: single requester wins; both -> RR alternates, fixed gives req0
    function automatic bit model_grant(bit r0, bit r1);
        bit w;
        if (r0 && r1) w = RR ? ~m_last : 1'b0;
        else          w = r1;
        m_last = w;
        return w;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; rw0_n = 1'b0; rw1_n = 1'b0;
        addr0 = 8'h11; addr1 = 8'h22; wdata0 = 8'h33; wdata1 = 8'h44;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({ack0, ack1, busy} !== 3'b000)
            $display("FAIL reset_ctrl: got ack0/ack1/busy=%b required 000", {ack0, ack1, busy});
        tests++;
        if ({ram_RWn, ram_raddr, ram_waddr, ram_wdata} !== {1'b1, 24'h0})
            $display("FAIL reset_ram: got RWn=%b ra=%h wa=%h wd=%h required 1/00/00/00",
                     ram_RWn, ram_raddr, ram_waddr, ram_wdata);
        tests++;
        if (rdata !== 8'h00)
            $display("FAIL reset_rdata: got %h required 00", rdata);
        fails += ({ack0, ack1, busy} !== 3'b000) + ({ram_RWn, ram_raddr, ram_waddr, ram_wdata} !== {1'b1, 24'h0})
                 + (rdata !== 8'h00);
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
        m_last = 1'b1; m_rdata = 8'h00;
    endtask

    task automatic test_idle;
        logic [27:0] obs;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            obs = {ram_RWn, ram_raddr, ram_waddr, ram_wdata, busy, ack0, ack1};
            tests++;
            if (obs !== {1'b1, 24'h0, 3'b000}) begin
                fails++;
                $display("FAIL idle cycle %0d: got %h required %h", n, obs, {1'b1, 24'h0, 3'b000});
            end
        end
    endtask

    task automatic test_write_read;
        int got;
        bit w;
        req0 = 1'b1; rw0_n = 1'b0; addr0 = 8'd5; wdata0 = 8'd29;
        w = model_grant(1'b1, 1'b0);
        @(posedge clk); #1;
        tests++;
        if ({ram_RWn, ram_raddr, ram_waddr, ram_wdata} !== {1'b0, 8'd5, 8'd5, 8'd29}) begin
            fails++;
            $display("FAIL wr_access: got RWn=%b ra=%0d wa=%0d wd=%0d required 0/5/5/29",
                     ram_RWn, ram_raddr, ram_waddr, ram_wdata);
        end
        @(posedge clk); #1;
        tests++;
        if ({ack0, ack1, ram_RWn} !== {~w, w, 1'b1}) begin
            fails++;
            $display("FAIL wr_ack: got ack0/ack1/RWn=%b required 101", {ack0, ack1, ram_RWn});
        end
        req0 = 1'b0;
        ref_mem[5] = 8'd29;
        @(posedge clk); #1;
        req1 = 1'b1; rw1_n = 1'b1; addr1 = 8'd5;
        w = model_grant(1'b0, 1'b1);
        got = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (ack1 && got == 0) begin
                got = n;
                req1 = 1'b0;
                tests++;
                if (rdata !== ref_mem[5]) begin
                    fails++;
                    $display("FAIL rd_data: got %0d required %0d", rdata, ref_mem[5]);
                end
            end
        end
        m_rdata = ref_mem[5];
        tests++;
        if (got !== 3) begin
            fails++;
            $display("FAIL rd_latency: got ack1 at cycle %0d required 3", got);
        end
    endtask

    task automatic test_dual;
        int t0, t1, e0, e1;
        bit w1, w2;
        logic [7:0] a0, a1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 1'b1; m_rdata = 8'h00;
        a0 = 8'h20 + 8'($urandom_range(0, 7));
        a1 = 8'h28 + 8'($urandom_range(0, 7));
        req0 = 1'b1; rw0_n = 1'b1; addr0 = a0;
        req1 = 1'b1; rw1_n = 1'b1; addr1 = a1;
        w1 = model_grant(1'b1, 1'b1);
        w2 = model_grant(w1, ~w1);
        e0 = w1 ? 7 : 3;
        e1 = w2 ? 7 : 3;
        t0 = 0; t1 = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (ack0 && t0 == 0) begin
                t0 = n; req0 = 1'b0;
                tests++;
                if (rdata !== ref_mem[a0]) begin
                    fails++;
                    $display("FAIL dual_rdata0: got %h required %h", rdata, ref_mem[a0]);
                end
            end
            if (ack1 && t1 == 0) begin
                t1 = n; req1 = 1'b0;
                tests++;
                if (rdata !== ref_mem[a1]) begin
                    fails++;
                    $display("FAIL dual_rdata1: got %h required %h", rdata, ref_mem[a1]);
                end
            end
        end
        m_rdata = ref_mem[a1];
        tests++;
        if (t0 !== e0 || t1 !== e1) begin
            fails++;
            $display("FAIL dual_order: got ack0@%0d ack1@%0d required ack0@%0d ack1@%0d", t0, t1, e0, e1);
        end
    endtask

    task automatic test_sustain;
        int n1, got1;
        bit w;
        logic [1:0] exp;
        req0 = 1'b1; rw0_n = 1'b0; addr0 = 8'h40; wdata0 = 8'($urandom);
        req1 = 1'b1; rw1_n = 1'b0; addr1 = 8'h41; wdata1 = 8'($urandom);
        n1 = 0; got1 = 0;
        // Each write holds the bus 3 cycles (grant, ACCESS, ACK) before the next arbitration
        for (int n = 1; n <= 23; n++) begin
            @(posedge clk); #1;
            exp = 2'b00;
            if (n % 3 == 2) begin
                w = model_grant(1'b1, 1'b1);
                exp = w ? 2'b01 : 2'b10;
                if (w) begin ref_mem[8'h41] = wdata1; n1++; end
                else   ref_mem[8'h40] = wdata0;
            end
            if (ack1) got1++;
            tests++;
            if ({ack0, ack1} !== exp) begin
                fails++;
                $display("FAIL sustain cycle %0d: got ack0/ack1=%b required %b", n, {ack0, ack1}, exp);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tests++;
        if (got1 !== n1) begin
            fails++;
            $display("FAIL sustain_count: got %0d ack1 pulses required %0d", got1, n1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        int got;
        bit w;
        logic [35:0] obs;
        // Reset in the same cycle as the request: no grant, no RAM write
        req0 = 1'b1; rw0_n = 1'b0; addr0 = 8'd3; wdata0 = 8'd12; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req0 = 1'b0;
        m_last = 1'b1; m_rdata = 8'h00;
        @(posedge clk); #1;
        tests++;
        if ({busy, ram_RWn, ack0, ack1} !== 4'b0100) begin
            fails++;
            $display("FAIL abort_idle: got busy/RWn/ack0/ack1=%b required 0100", {busy, ram_RWn, ack0, ack1});
        end
        req1 = 1'b1; rw1_n = 1'b1; addr1 = 8'd3;
        w = model_grant(1'b0, 1'b1);
        got = 0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (ack1 && got == 0) begin
                got = n; req1 = 1'b0;
                tests++;
                if (rdata !== ref_mem[3] || rdata === 8'd12) begin
                    fails++;
                    $display("FAIL abort_readback: got %h required %h", rdata, ref_mem[3]);
                end
            end
        end
        m_rdata = ref_mem[3];
        tests++;
        if (got !== 3) begin
            fails++;
            $display("FAIL abort_rd_latency: got ack1 at cycle %0d required 3", got);
        end
        // Reset during ACCESS: the strobe already on the bus is sampled at that edge, nothing after it
        req0 = 1'b1; rw0_n = 1'b0; addr0 = 8'd3; wdata0 = 8'd12;
        @(posedge clk); #1;
        tests++;
        if ({ram_RWn, ram_waddr, ram_wdata} !== {1'b0, 8'd3, 8'd12}) begin
            fails++;
            $display("FAIL abort_access: got RWn=%b wa=%0d wd=%0d required 0/3/12", ram_RWn, ram_waddr, ram_wdata);
        end
        rst = 1'b1; req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 1'b1; m_rdata = 8'h00;
        ref_mem[3] = 8'd12;
        for (int n = 0; n < 4; n++) begin
            obs = {ack0, ack1, busy, ram_RWn, ram_raddr, ram_waddr, ram_wdata, rdata};
            tests++;
            if (obs !== {4'b0001, 32'h0}) begin
                fails++;
                $display("FAIL abort_after cycle %0d: got %h required %h", n, obs, {4'b0001, 32'h0});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random;
        bit         who [2];
        bit         rwk [2];
        logic [7:0] ad [2], wd [2], rd [2];
        int         g [2], lat [2];
        int         cnt, end_n;
        bit         en0, en1, r0, r1, e_ack0, e_ack1, e_busy, e_rwn;
        logic [7:0] a0, a1, d0, d1, e_ad, e_wd;
        logic [35:0] obs, exp;
        for (int it = 0; it < 40; it++) begin
            en0 = 1'($urandom_range(0, 1));
            en1 = 1'($urandom_range(0, 1));
            if (!en0 && !en1) en0 = 1'b1;
            r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
            a0 = 8'h10 + 8'($urandom_range(0, 3)); a1 = 8'h10 + 8'($urandom_range(0, 3));
            d0 = 8'($urandom); d1 = 8'($urandom);
            req0 = en0; rw0_n = r0; addr0 = a0; wdata0 = d0;
            req1 = en1; rw1_n = r1; addr1 = a1; wdata1 = d1;
            who[0] = model_grant(en0, en1);
            cnt = 1;
            if (en0 && en1) begin
                who[1] = model_grant(who[0], ~who[0]);
                cnt = 2;
            end
            for (int k = 0; k < cnt; k++) begin
                rwk[k] = who[k] ? r1 : r0;
                ad[k]  = who[k] ? a1 : a0;
                wd[k]  = who[k] ? d1 : d0;
                lat[k] = rwk[k] ? 3 : 2;
                g[k]   = (k == 0) ? 0 : g[0] + lat[0] + 1;
                if (rwk[k]) rd[k] = ref_mem[ad[k]];
                else        ref_mem[ad[k]] = wd[k];
            end
            end_n = g[cnt-1] + lat[cnt-1];
            for (int n = 1; n <= end_n + 1; n++) begin
                @(posedge clk); #1;
                e_ack0 = 1'b0; e_ack1 = 1'b0; e_busy = 1'b0; e_rwn = 1'b1; e_ad = 8'h00; e_wd = 8'h00;
                for (int k = 0; k < cnt; k++) begin
                    if (n > g[k] && n <= g[k] + lat[k]) e_busy = 1'b1;
                    if (n == g[k] + 1) begin e_rwn = rwk[k]; e_ad = ad[k]; e_wd = wd[k]; end
                    if (n == g[k] + lat[k]) begin
                        if (who[k]) e_ack1 = 1'b1; else e_ack0 = 1'b1;
                        if (rwk[k]) m_rdata = rd[k];
                    end
                end
                obs = {ack0, ack1, busy, ram_RWn, ram_raddr, ram_waddr, ram_wdata, rdata};
                exp = {e_ack0, e_ack1, e_busy, e_rwn, e_ad, e_ad, e_wd, m_rdata};
                tests++;
                if (obs !== exp) begin
                    fails++;
                    $display("FAIL random it=%0d cycle=%0d: got %h required %h", it, n, obs, exp);
                end
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
            end
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
        test_reset;
        test_idle;
        test_write_read;
        test_dual;
        test_sustain;
        test_abort;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
